window_mac4x4: RTL and testbench

Downstream compute stage of the CNN datapath. Consumes the 16-byte 4x4 pixel window produced by the row/window buffer and multiplies it element-wise against a stored 4x4 signed filter. It accumulates one window row per cycle and emits both a full-precision partial sum and a ReLU'd, shifted, saturated 8-bit activation. It uses a ready/start handshake so the window controller can advance `readIdx` and shift rows only when the engine can accept a new window.

---
 rtl/window_mac4x4.sv | 99 +++++++++
 tb/tb_window_mac4x4.sv | 192 +++++++++++++++++++
 2 files changed

// File: rtl/window_mac4x4.sv
// 4x4 window x signed filter multiply-accumulate, one window row per cycle.
// Emits the full 20-bit sum and a ReLU'd, shifted, 8-bit saturated activation.
module window_mac4x4 #(
  parameter int SHIFT = 7
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [127:0] window,
  input  logic         start,
  input  logic         load_w,
  input  logic [127:0] weights,
  output logic         ready,
  output logic         busy,
  output logic         valid,
  output logic [19:0]  psum,
  output logic [7:0]   act
);

  typedef enum logic [1:0] {S_IDLE, S_ACC, S_DONE} state_t;

  state_t             r_state, w_next;
  logic [1:0]         r_row;
  logic signed [19:0] r_acc;
  logic [15:0][7:0]   r_win;
  logic [15:0][7:0]   r_wt;
  logic signed [19:0] r_psum;
  logic [7:0]         r_act;

  logic signed [15:0] w_prod [4];
  logic signed [17:0] w_row_sum;
  logic signed [19:0] w_sum;
  logic signed [19:0] w_shr;
  logic [7:0]         w_act;

  // Pixels are unsigned, so zero-extend before the signed multiply.
  for (genvar c = 0; c < 4; c++) begin : g_lane
    logic [3:0] w_idx;
    assign w_idx     = {r_row, 2'(c)};
    assign w_prod[c] = $signed({8'd0, r_win[w_idx]}) *
                       $signed({{8{r_wt[w_idx][7]}}, r_wt[w_idx]});
  end

  assign w_row_sum = {{2{w_prod[0][15]}}, w_prod[0]} + {{2{w_prod[1][15]}}, w_prod[1]}
                   + {{2{w_prod[2][15]}}, w_prod[2]} + {{2{w_prod[3][15]}}, w_prod[3]};
  assign w_sum     = r_acc + {{2{w_row_sum[17]}}, w_row_sum};
  assign w_shr     = w_sum >>> SHIFT;
  assign w_act     = w_sum[19]          ? 8'd0   :
                     (w_shr > 20'sd255) ? 8'd255 : w_shr[7:0];

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:  if (start) w_next = S_ACC;
      S_ACC:   if (r_row == 2'd3) w_next = S_DONE;
      S_DONE:  w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_IDLE;
      r_row   <= '0;
      r_acc   <= '0;
      r_win   <= '0;
      r_wt    <= '0;
      r_psum  <= '0;
      r_act   <= '0;
    end else begin
      r_state <= w_next;
      case (r_state)
        S_IDLE: begin
          if (load_w) r_wt <= weights;
          if (start) begin
            r_win <= window;
            r_acc <= '0;
            r_row <= '0;
          end
        end
        S_ACC: begin
          r_acc <= w_sum;
          r_row <= r_row + 2'd1;
          if (r_row == 2'd3) begin
            r_psum <= w_sum;
            r_act  <= w_act;
          end
        end
        default: ;
      endcase
    end
  end

  assign ready = (r_state == S_IDLE);
  assign busy  = (r_state == S_ACC);
  assign valid = (r_state == S_DONE);
  assign psum  = r_psum;
  assign act   = r_act;

endmodule

// File: tb/tb_window_mac4x4.sv
// Directed bench for window_mac4x4; a SHIFT=7 and a SHIFT=0 instance share stimulus.
module tb_window_mac4x4;

  logic         clk = 1'b0;
  logic         rst;
  logic [127:0] window;
  logic         start;
  logic         load_w;
  logic [127:0] weights;
  logic         ready, busy, valid;
  logic [19:0]  psum;
  logic [7:0]   act;
  logic         ready0, busy0, valid0;
  logic [19:0]  psum0;
  logic [7:0]   act0;

  int checks = 0;
  int errors = 0;

  window_mac4x4 #(.SHIFT(7)) u_dut (
    .clk(clk), .rst(rst), .window(window), .start(start), .load_w(load_w),
    .weights(weights), .ready(ready), .busy(busy), .valid(valid),
    .psum(psum), .act(act)
  );

  window_mac4x4 #(.SHIFT(0)) u_dut0 (
    .clk(clk), .rst(rst), .window(window), .start(start), .load_w(load_w),
    .weights(weights), .ready(ready0), .busy(busy0), .valid(valid0),
    .psum(psum0), .act(act0)
  );

  always #5 clk = ~clk;

  // Inputs change and outputs are sampled 1ns after each rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic load_weights(input logic [127:0] w);
    weights = w;
    load_w  = 1'b1;
    tick();
    load_w  = 1'b0;
  endtask

  // Pulses start (optionally with load_w) and waits for valid; lat=0 on timeout.
  task automatic run_window(input logic [127:0] win, input logic ld, input logic [127:0] w,
                            output int lat);
    window  = win;
    weights = w;
    load_w  = ld;
    start   = 1'b1;
    tick();
    start   = 1'b0;
    load_w  = 1'b0;
    window  = '1;
    lat     = 0;
    for (int i = 1; i <= 10; i++) begin
      tick();
      if (valid) begin
        lat = i;
        break;
      end
    end
  endtask

  task automatic test_reset();
    int npulse;
    rst = 1'b1; start = 1'b0; load_w = 1'b0; window = '0; weights = '0;
    tick(); tick();
    rst = 1'b0;
    tick();
    checks++; if (ready !== 1'b1) begin errors++; $display("FAIL reset_ready got %b want 1", ready); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %b want 0", busy); end
    checks++; if (valid !== 1'b0) begin errors++; $display("FAIL reset_valid got %b want 0", valid); end
    checks++; if (psum !== 20'd0) begin errors++; $display("FAIL reset_psum got %0d want 0", psum); end
    checks++; if (act !== 8'd0) begin errors++; $display("FAIL reset_act got %0d want 0", act); end
    npulse = 0;
    for (int i = 0; i < 20; i++) begin
      tick();
      if (valid) npulse++;
    end
    checks++; if (npulse !== 0) begin errors++; $display("FAIL idle_no_valid got %0d pulses want 0", npulse); end
  endtask

  task automatic test_max_pos();
    int lat;
    load_weights({16{8'sd127}});
    run_window({16{8'hFF}}, 1'b0, '0, lat);
    checks++; if (lat !== 4) begin errors++; $display("FAIL maxpos_latency got %0d want 4", lat); end
    checks++; if ($signed(psum) !== 20'sd518160) begin errors++; $display("FAIL maxpos_psum got %0d want 518160", $signed(psum)); end
    checks++; if (act !== 8'd255) begin errors++; $display("FAIL maxpos_act got %0d want 255", act); end
    tick();
    checks++; if (valid !== 1'b0 || ready !== 1'b1) begin errors++; $display("FAIL maxpos_return got valid=%b ready=%b want 0 1", valid, ready); end
  endtask

  task automatic test_max_neg();
    int lat;
    load_weights({16{8'h80}});
    run_window({16{8'hFF}}, 1'b0, '0, lat);
    checks++; if ($signed(psum) !== -20'sd522240) begin errors++; $display("FAIL maxneg_psum got %0d want -522240", $signed(psum)); end
    checks++; if (act !== 8'd0) begin errors++; $display("FAIL maxneg_act got %0d want 0", act); end
    tick();
  endtask

  task automatic test_single_tap();
    int lat;
    logic [127:0] w, win;
    w = '0; w[47:40] = 8'd3;
    win = '0; win[47:40] = 8'd50; win[55:48] = 8'd200;
    load_weights(w);
    run_window(win, 1'b0, '0, lat);
    checks++; if (psum0 !== 20'd150) begin errors++; $display("FAIL tap1_psum got %0d want 150", psum0); end
    checks++; if (act0 !== 8'd150) begin errors++; $display("FAIL tap1_act_s0 got %0d want 150", act0); end
    checks++; if (act !== 8'd1) begin errors++; $display("FAIL tap1_act_s7 got %0d want 1", act); end
    tick();
    // start and load_w together: new weights apply to this window.
    w = '0; w[47:40] = 8'd100;
    win = '0; win[47:40] = 8'd200;
    run_window(win, 1'b1, w, lat);
    checks++; if (lat !== 4) begin errors++; $display("FAIL tap2_latency got %0d want 4", lat); end
    checks++; if (psum0 !== 20'd20000) begin errors++; $display("FAIL tap2_psum got %0d want 20000", psum0); end
    checks++; if (act0 !== 8'd255) begin errors++; $display("FAIL tap2_act_s0 got %0d want 255", act0); end
    checks++; if (act !== 8'd156) begin errors++; $display("FAIL tap2_act_s7 got %0d want 156", act); end
    tick();
  endtask

  task automatic test_ignored_inputs();
    int lat;
    load_weights({16{8'h01}});
    window = {16{8'h02}};
    start  = 1'b1;
    tick();
    window  = {16{8'h07}};
    weights = {16{8'h02}};
    load_w  = 1'b1;
    tick(); tick(); tick();
    start  = 1'b0;
    load_w = 1'b0;
    tick();
    checks++; if (valid !== 1'b1) begin errors++; $display("FAIL ign_valid got %b want 1", valid); end
    checks++; if (psum !== 20'd32) begin errors++; $display("FAIL ign_psum got %0d want 32", psum); end
    tick();
    checks++; if (ready !== 1'b1 || busy !== 1'b0 || valid !== 1'b0) begin
      errors++; $display("FAIL ign_no_restart got ready=%b busy=%b valid=%b want 1 0 0", ready, busy, valid);
    end
    run_window({16{8'h03}}, 1'b0, {16{8'h05}}, lat);
    checks++; if (psum !== 20'd48) begin errors++; $display("FAIL ign_old_weights got %0d want 48", psum); end
    tick();
  endtask

  task automatic test_reset_mid_op();
    int lat, npulse;
    window = {16{8'h09}};
    start  = 1'b1;
    tick();
    start = 1'b0;
    tick(); tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    checks++; if (ready !== 1'b1 || busy !== 1'b0 || valid !== 1'b0) begin
      errors++; $display("FAIL rstmid_state got ready=%b busy=%b valid=%b want 1 0 0", ready, busy, valid);
    end
    checks++; if (psum !== 20'd0) begin errors++; $display("FAIL rstmid_psum got %0d want 0", psum); end
    npulse = 0;
    for (int i = 0; i < 6; i++) begin
      tick();
      if (valid) npulse++;
    end
    checks++; if (npulse !== 0) begin errors++; $display("FAIL rstmid_no_valid got %0d pulses want 0", npulse); end
    load_weights({16{8'h01}});
    run_window({16{8'h04}}, 1'b0, '0, lat);
    checks++; if (lat !== 4) begin errors++; $display("FAIL rstmid_latency got %0d want 4", lat); end
    checks++; if (psum !== 20'd64) begin errors++; $display("FAIL rstmid_psum_after got %0d want 64", psum); end
    checks++; if (act !== 8'd0) begin errors++; $display("FAIL rstmid_act_after got %0d want 0", act); end
    tick();
  endtask

  initial begin
    test_reset();
    test_max_pos();
    test_max_neg();
    test_single_tap();
    test_ignored_inputs();
    test_reset_mid_op();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
